instr_encode_loader: RTL and testbench
======================================

Name: instr_encode_loader

Overview:
- Encodes the opposite direction from the instruction decoder.
- Accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit ISA words.
- Writes the words sequentially into instruction memory, so a testbench or boot sequencer can stream a program into imem before release.
- Sits between the program source and the imem write port.

Parameters:
- ADDR_W, 12, imem word-address width.
- BASE_ADDR, 0, first imem address written after reset or start.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  re-arm pulse, honoured only in DONE.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  loader can accept a bundle.
- in_op  in  5  opcode.
- in_alu_op  in  5  R-type ALU op.
- in_rd, in_rs, in_rt, in_shamt  in  5 each  register and shamt fields.
- in_imm  in  17  I-type immediate.
- in_target  in  27  JI-type target.
- in_last  in  1  final instruction of the program.
- imem_addr  out  ADDR_W  write address.
- imem_data  out  32  encoded word.
- imem_wren  out  1  write strobe.
- load_done  out  1  program loaded.
- err_illegal  out  1  sticky, unknown opcode seen.
- err_overflow  out  1  sticky, address space exhausted.
- word_count  out  ADDR_W+1  words written since reset or start.
- checksum  out  32  see Optional Feature.

Behaviour:
- Reset (synchronous, active-high) values:
  - state=IDLE, imem_addr=BASE_ADDR.
  - imem_wren=0, imem_data=0.
  - load_done=0, err_illegal=0, err_overflow=0.
  - word_count=0, checksum=0.
  - Reset mid-write aborts the write; no strobe is issued in the reset cycle.
- Opcode classes:
  - R: 00000.
  - I: addi 00101, sw 00111, lw 01000, bne 00010, blt 00110.
  - JI: j 00001, jal 00011, bex 10110, setx 10101.
  - JII: jr 00100.
  - Any other opcode is illegal.
- Encoding:
  - R = {op, rd, rs, rt, shamt, alu_op, 2'b00}.
  - I = {op, rd, rs, imm}.
  - JI = {op, target}.
  - JII = {op, rd, 22'b0}.
  - Fields not used by the class are ignored.
- FSM IDLE:
  - in_ready=1.
  - If in_valid and the opcode is legal: register the encoded word and in_last, go to WRITE.
  - If in_valid and the opcode is illegal: consume the bundle, set err_illegal, stay in IDLE, write nothing.
- FSM WRITE:
  - in_ready=0, imem_wren=1 for exactly one cycle, imem_data=registered word.
  - Next cycle: imem_addr+=1 and word_count+=1.
  - If in_last, go to DONE.
  - Else if imem_addr was all-ones, set err_overflow and go to DONE; the address does not wrap.
  - Else return to IDLE.
- FSM DONE:
  - load_done=1, in_ready=0, inputs ignored.
  - start=1 clears load_done and word_count, sets imem_addr=BASE_ADDR, goes to IDLE.
  - Error flags persist across start and clear only on reset.
  - start outside DONE is ignored.
- Throughput and latency:
  - One word per 2 cycles.
  - Latency from accept edge to imem_wren high is 1 cycle.
- Illegal bundle with in_last=1: err_illegal is set and the loader moves to DONE without writing.

Optional Feature:
- Macro: ENCODE_CHECKSUM_EN.
- Defined: on each write strobe, checksum <= checksum ^ {imem_data[15:0], imem_data[31:16]} ^ imem_addr (zero-extended). Cleared on reset and start.
- Undefined: checksum is tied to 32'h0 and no accumulator logic is built.

Decomposition:
- Shared package holds:
  - the 5-bit opcode constants (shared with the decoder);
  - class codes R/I/JI/JII;
  - field bit positions (31:27, 26:22, 21:17, 16:12, 11:7, 6:2);
  - FSM state encoding.
- Sub-module instr_field_packer: purely combinational. Takes the opcode and fields, returns the 32-bit word and a legal flag. Reused by any future assembler.
- The loader wraps the packer with the FSM, address counter and flags.

Test Plan:
- Reset, then addi rd=1 rs=0 imm=5, last=0 -> imem_wren at addr 0 with data 0x28400005; in_ready low for 1 cycle.
- add rd=3 rs=1 rt=2 alu=0, then sub with alu=1 (last=1) -> addr 0: 0x00C22000, addr 1: 0x00C22004; load_done=1, word_count=2.
- j target=100, jr rd=31, setx target=7 (last) -> 0x08000064, 0x27C00000, 0xA8000007 at addrs 0, 1, 2.
- in_op=11111 in IDLE -> no imem_wren, err_illegal=1, imem_addr unchanged; a following legal word is written at the same address.
- ADDR_W=2, five bundles with no last -> four writes (addr 0-3), err_overflow=1, DONE, fifth bundle never accepted; start -> addr 0, load_done=0.
- Assert reset during WRITE -> imem_wren=0 that cycle and all outputs at reset values the next cycle.

Source files
------------

// File: rtl/instr_encode_loader_pkg.sv
// Shared ISA constants, field layout and loader state encoding for the encoder/loader.
package instr_encode_loader_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned IMM_W  = 17;
    localparam int unsigned TGT_W  = 27;

    localparam logic [OP_W-1:0] OP_RTYPE = 5'b00000;
    localparam logic [OP_W-1:0] OP_J     = 5'b00001;
    localparam logic [OP_W-1:0] OP_BNE   = 5'b00010;
    localparam logic [OP_W-1:0] OP_JAL   = 5'b00011;
    localparam logic [OP_W-1:0] OP_JR    = 5'b00100;
    localparam logic [OP_W-1:0] OP_ADDI  = 5'b00101;
    localparam logic [OP_W-1:0] OP_BLT   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SW    = 5'b00111;
    localparam logic [OP_W-1:0] OP_LW    = 5'b01000;
    localparam logic [OP_W-1:0] OP_SETX  = 5'b10101;
    localparam logic [OP_W-1:0] OP_BEX   = 5'b10110;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 27;
    localparam int unsigned RD_MSB    = 26;
    localparam int unsigned RD_LSB    = 22;
    localparam int unsigned RS_MSB    = 21;
    localparam int unsigned RS_LSB    = 17;
    localparam int unsigned RT_MSB    = 16;
    localparam int unsigned RT_LSB    = 12;
    localparam int unsigned SHAMT_MSB = 11;
    localparam int unsigned SHAMT_LSB = 7;
    localparam int unsigned ALU_MSB   = 6;
    localparam int unsigned ALU_LSB   = 2;
    localparam int unsigned IMM_MSB   = IMM_W - 1;
    localparam int unsigned TGT_MSB   = TGT_W - 1;

    typedef enum logic [1:0] {
        CLS_R   = 2'd0,
        CLS_I   = 2'd1,
        CLS_JI  = 2'd2,
        CLS_JII = 2'd3
    } instr_class_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } load_state_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] alu_op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] shamt;
        logic [IMM_W-1:0] imm;
        logic [TGT_W-1:0] target;
    } instr_fields_t;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: decoded fields -> 32-bit ISA word plus legal-opcode flag.
module instr_field_packer
    import instr_encode_loader_pkg::*;
(
    input  instr_fields_t       fields,
    output logic [WORD_W-1:0]   word,
    output logic                legal
);

    instr_class_e cls;

    always_comb begin
        legal = 1'b1;
        cls   = CLS_R;
        word  = '0;
        case (fields.op)
            OP_RTYPE:                             cls = CLS_R;
            OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT: cls = CLS_I;
            OP_J, OP_JAL, OP_BEX, OP_SETX:        cls = CLS_JI;
            OP_JR:                                cls = CLS_JII;
            default:                              legal = 1'b0;
        endcase

        word[OP_MSB:OP_LSB] = fields.op;
        case (cls)
            CLS_R: begin
                word[RD_MSB:RD_LSB]       = fields.rd;
                word[RS_MSB:RS_LSB]       = fields.rs;
                word[RT_MSB:RT_LSB]       = fields.rt;
                word[SHAMT_MSB:SHAMT_LSB] = fields.shamt;
                word[ALU_MSB:ALU_LSB]     = fields.alu_op;
            end
            CLS_I: begin
                word[RD_MSB:RD_LSB] = fields.rd;
                word[RS_MSB:RS_LSB] = fields.rs;
                word[IMM_MSB:0]     = fields.imm;
            end
            CLS_JI:  word[TGT_MSB:0]     = fields.target;
            CLS_JII: word[RD_MSB:RD_LSB] = fields.rd;
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Streams encoded instructions into imem one word per two cycles.
// Optional running checksum of written words enabled by ENCODE_CHECKSUM_EN.
module instr_encode_loader
    import instr_encode_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     in_op,
    input  logic [REG_W-1:0]    in_alu_op,
    input  logic [REG_W-1:0]    in_rd,
    input  logic [REG_W-1:0]    in_rs,
    input  logic [REG_W-1:0]    in_rt,
    input  logic [REG_W-1:0]    in_shamt,
    input  logic [IMM_W-1:0]    in_imm,
    input  logic [TGT_W-1:0]    in_target,
    input  logic                in_last,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [WORD_W-1:0]   imem_data,
    output logic                imem_wren,
    output logic                load_done,
    output logic                err_illegal,
    output logic                err_overflow,
    output logic [ADDR_W:0]     word_count,
    output logic [WORD_W-1:0]   checksum
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    load_state_e          state, state_next;
    instr_fields_t        fields;
    logic [WORD_W-1:0]    packed_word;
    logic                 packed_legal;
    logic [WORD_W-1:0]    word_q;
    logic                 last_q;
    logic                 accept;
    logic                 illegal_seen;
    logic                 overflow_hit;
    logic                 rearm;

    assign fields = '{op: in_op, alu_op: in_alu_op, rd: in_rd, rs: in_rs, rt: in_rt,
                      shamt: in_shamt, imm: in_imm, target: in_target};

    instr_field_packer u_packer (
        .fields (fields),
        .word   (packed_word),
        .legal  (packed_legal)
    );

    assign imem_data = word_q;

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Strobe is gated by reset so an aborted write never reaches imem.
    always_comb begin
        state_next   = state;
        in_ready     = 1'b0;
        imem_wren    = 1'b0;
        accept       = 1'b0;
        illegal_seen = 1'b0;
        overflow_hit = 1'b0;
        rearm        = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (packed_legal) begin
                        accept     = 1'b1;
                        state_next = S_WRITE;
                    end else begin
                        illegal_seen = 1'b1;
                        if (in_last) state_next = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                imem_wren = ~reset;
                if (last_q) begin
                    state_next = S_DONE;
                end else if (&imem_addr) begin
                    overflow_hit = 1'b1;
                    state_next   = S_DONE;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_DONE: begin
                if (start) begin
                    rearm      = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            imem_addr    <= ADDR_W'(BASE_ADDR);
            word_q       <= '0;
            last_q       <= 1'b0;
            load_done    <= 1'b0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
            word_count   <= '0;
        end else begin
            load_done <= (state_next == S_DONE);
            if (accept) begin
                word_q <= packed_word;
                last_q <= in_last;
            end
            if (illegal_seen) err_illegal  <= 1'b1;
            if (overflow_hit) err_overflow <= 1'b1;
            if (state == S_WRITE) begin
                word_count <= word_count + CNT_W'(1);
                if (!(&imem_addr)) imem_addr <= imem_addr + ADDR_W'(1);
            end
            if (rearm) begin
                imem_addr  <= ADDR_W'(BASE_ADDR);
                word_count <= '0;
            end
        end
    end

`ifdef ENCODE_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset || rearm)
            checksum <= '0;
        else if (state == S_WRITE)
            checksum <= checksum ^ {imem_data[15:0], imem_data[31:16]} ^ WORD_W'(imem_addr);
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: directed program cases, random programs, overflow on a 2-bit instance.
`timescale 1ns/1ps
module tb_instr_encode_loader;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0, in_alu_op = '0, in_rd = '0, in_rs = '0, in_rt = '0, in_shamt = '0;
    logic [16:0] in_imm = '0;
    logic [26:0] in_target = '0;
    logic        in_last = 1'b0;
    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_wren, load_done, err_illegal, err_overflow;
    logic [12:0] word_count;
    logic [31:0] checksum;

    logic        s_start = 1'b0;
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [4:0]  s_in_op = '0, s_in_rd = '0;
    logic [16:0] s_in_imm = '0;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_data;
    logic        s_imem_wren, s_load_done, s_err_illegal, s_err_overflow;
    logic [2:0]  s_word_count;
    logic [31:0] s_checksum;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    instr_encode_loader #(.ADDR_W(12), .BASE_ADDR(0)) dut (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_alu_op(in_alu_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_addr(imem_addr), .imem_data(imem_data), .imem_wren(imem_wren),
        .load_done(load_done), .err_illegal(err_illegal), .err_overflow(err_overflow),
        .word_count(word_count), .checksum(checksum)
    );

    instr_encode_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_s (
        .clock(clock), .reset(reset), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_op(s_in_op), .in_alu_op(5'd0), .in_rd(s_in_rd), .in_rs(5'd0), .in_rt(5'd0),
        .in_shamt(5'd0), .in_imm(s_in_imm), .in_target(27'd0), .in_last(1'b0),
        .imem_addr(s_imem_addr), .imem_data(s_imem_data), .imem_wren(s_imem_wren),
        .load_done(s_load_done), .err_illegal(s_err_illegal), .err_overflow(s_err_overflow),
        .word_count(s_word_count), .checksum(s_checksum)
    );

    // Reference model state
    exp_t        q[$];
    exp_t        sq[$];
    int          m_addr, m_count;
    bit          m_done, m_ill, m_ovf;
    logic [31:0] m_cs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [4:0] op);
        return op inside {5'b00000, 5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110,
                          5'b00001, 5'b00011, 5'b10110, 5'b10101, 5'b00100};
    endfunction

    function automatic logic [31:0] encode(input logic [4:0] op, alu, rd, rs, rt, sh,
                                           input logic [16:0] imm, input logic [26:0] tgt);
        longint w;
        w = longint'(op) * 2**27;
        if (op == 5'b00000)
            w += longint'(rd) * 2**22 + longint'(rs) * 2**17 + longint'(rt) * 2**12
               + longint'(sh) * 2**7 + longint'(alu) * 4;
        else if (op inside {5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110})
            w += longint'(rd) * 2**22 + longint'(rs) * 2**17 + longint'(imm);
        else if (op inside {5'b00001, 5'b00011, 5'b10110, 5'b10101})
            w += longint'(tgt);
        else
            w += longint'(rd) * 2**22;
        return w[31:0];
    endfunction

    function automatic logic [31:0] exp_checksum();
`ifdef ENCODE_CHECKSUM_EN
        return m_cs;
`else
        return 32'h0;
`endif
    endfunction

    task automatic model_reset();
        m_addr = 0; m_count = 0; m_done = 0; m_ill = 0; m_ovf = 0; m_cs = '0;
        q.delete();
    endtask

    task automatic model_start();
        if (m_done) begin
            m_done = 0; m_addr = 0; m_count = 0; m_cs = '0;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".in_ready"}, in_ready, !m_done);
        check({tag, ".addr"}, imem_addr, m_addr);
        check({tag, ".count"}, word_count, m_count);
        check({tag, ".done"}, load_done, m_done);
        check({tag, ".err_ill"}, err_illegal, m_ill);
        check({tag, ".err_ovf"}, err_overflow, m_ovf);
        check({tag, ".checksum"}, checksum, exp_checksum());
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        model_start();
    endtask

    // Offer one bundle; model is updated on the accepting edge.
    task automatic send(input logic [4:0] op, alu, rd, rs, rt, sh, input logic [16:0] imm,
                        input logic [26:0] tgt, input bit last, input bit rst_mid);
        bit acc, was_done, allones;
        logic [31:0] w;
        was_done = m_done;
        acc = 0;
        in_op = op; in_alu_op = alu; in_rd = rd; in_rs = rs; in_rt = rt; in_shamt = sh;
        in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (in_ready) begin
                @(posedge clock);
                acc = 1;
                break;
            end
            @(posedge clock); #1;
        end
        check("accepted", acc, !was_done);
        if (acc) begin
            #1;
            in_valid = 1'b0;
            if (is_legal(op)) begin
                w = encode(op, alu, rd, rs, rt, sh, imm, tgt);
                q.push_back('{a: 12'(m_addr), d: w});
                m_cs = m_cs ^ {w[15:0], w[31:16]} ^ 32'(m_addr);
                allones = (m_addr == 4095);
                m_count++;
                if (!allones) m_addr++;
                if (last) m_done = 1;
                else if (allones) begin m_done = 1; m_ovf = 1; end
                if (rst_mid) reset = 1'b1;
                @(negedge clock);
                check("ready_low_in_write", in_ready, 1'b0);
                check("wren_in_write", imem_wren, !rst_mid);
            end else begin
                m_ill = 1;
                if (last) m_done = 1;
                check("illegal_no_wren", imem_wren, 1'b0);
                check("illegal_ready", in_ready, !m_done);
            end
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // Main-instance monitor
    always @(negedge clock) begin
        if (imem_wren) begin
            if (reset) begin
                total++; bad++;
                $display("FAIL wren_in_reset: got 1 expected 0 at %0t", $time);
            end else if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: addr %0h data %0h at %0t", imem_addr, imem_data, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("wr_addr", imem_addr, e.a);
                check("wr_data", imem_data, e.d);
            end
        end
    end

    // Small-instance monitor
    always @(negedge clock) begin
        if (s_imem_wren && !reset) begin
            if (sq.size() == 0) begin
                total++; bad++;
                $display("FAIL s_unexpected_write: addr %0h at %0t", s_imem_addr, $time);
            end else begin
                exp_t e;
                e = sq.pop_front();
                check("s_wr_addr", s_imem_addr, e.a[1:0]);
                check("s_wr_data", s_imem_data, e.d);
            end
        end
    end

    initial begin
        logic [4:0] legal_ops [11];
        legal_ops = '{5'b00000, 5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110,
                      5'b00001, 5'b00011, 5'b10110, 5'b10101, 5'b00100};
        model_reset();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_state("reset");
        check("reset.data", imem_data, 32'h0);
        check("reset.wren", imem_wren, 1'b0);

        // addi rd=1 rs=0 imm=5
        send(5'b00101, 0, 1, 0, 0, 0, 17'd5, 0, 0, 0);
        check("addi_word", encode(5'b00101, 0, 1, 0, 0, 0, 17'd5, 0), 32'h28400005);
        @(negedge clock);
        check_state("addi");

        // add / sub
        do_reset();
        send(5'b00000, 0, 3, 1, 2, 0, 0, 0, 0, 0);
        send(5'b00000, 1, 3, 1, 2, 0, 0, 0, 1, 0);
        @(negedge clock);
        check_state("addsub");
        check("addsub.count2", word_count, 13'd2);

        // j / jr / setx after re-arm
        pulse_start();
        send(5'b00001, 0, 0, 0, 0, 0, 0, 27'd100, 0, 0);
        send(5'b00100, 0, 31, 0, 0, 0, 0, 0, 0, 0);
        send(5'b10101, 0, 0, 0, 0, 0, 0, 27'd7, 1, 0);
        @(negedge clock);
        check_state("jump");

        // illegal opcode: consumed, no write, same address reused
        pulse_start();
        send(5'b11111, 0, 1, 2, 3, 4, 17'h1ffff, 27'h7ffffff, 0, 0);
        @(negedge clock);
        check_state("illegal");
        send(5'b01000, 0, 7, 8, 0, 0, 17'h0abc, 0, 0, 0);
        @(negedge clock);
        check_state("after_illegal");
        // start in IDLE is ignored
        pulse_start();
        @(negedge clock);
        check_state("start_ignored");
        // illegal with last -> DONE without writing
        send(5'b11000, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clock);
        check_state("illegal_last");
        pulse_start();
        @(negedge clock);
        check_state("err_persists");

        // random programs
        do_reset();
        for (int p = 0; p < 8; p++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                logic [4:0] op;
                if ($urandom_range(0, 7) == 0) begin
                    op = 5'($urandom_range(0, 31));
                    while (is_legal(op)) op = 5'($urandom_range(0, 31));
                end else begin
                    op = legal_ops[$urandom_range(0, 10)];
                end
                send(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                     17'($urandom), 27'($urandom), (k == len - 1), 0);
                if (m_done) break;
            end
            @(negedge clock);
            check_state("random");
            pulse_start();
        end

        // reset asserted during WRITE aborts the write
        send(5'b00101, 0, 2, 3, 0, 0, 17'd9, 0, 0, 1);
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        check_state("rst_mid");
        check("rst_mid.data", imem_data, 32'h0);

        // 2-bit address space: four writes then overflow
        for (int i = 0; i < 5; i++) begin
            bit acc;
            logic [31:0] w;
            acc = 0;
            s_in_op = 5'b00101; s_in_rd = 5'(i); s_in_imm = 17'(i + 1); s_in_valid = 1'b1;
            for (int n = 0; n < 8; n++) begin
                if (s_in_ready) begin
                    @(posedge clock);
                    acc = 1;
                    break;
                end
                @(posedge clock); #1;
            end
            if (acc) begin
                w = encode(5'b00101, 0, 5'(i), 0, 0, 0, 17'(i + 1), 0);
                sq.push_back('{a: 12'(i), d: w});
                #1;
            end
            s_in_valid = 1'b0;
            check("s_accept", acc, (i < 4));
        end
        @(negedge clock);
        check("s_done", s_load_done, 1'b1);
        check("s_ovf", s_err_overflow, 1'b1);
        check("s_count", s_word_count, 3'd4);
        check("s_addr_hold", s_imem_addr, 2'd3);
        check("s_ready", s_in_ready, 1'b0);
        check("s_err_ill", s_err_illegal, 1'b0);
        s_start = 1'b1;
        @(posedge clock); #1;
        s_start = 1'b0;
        @(negedge clock);
        check("s_rearm_addr", s_imem_addr, 2'd0);
        check("s_rearm_done", s_load_done, 1'b0);
        check("s_rearm_count", s_word_count, 3'd0);
        check("s_rearm_ovf", s_err_overflow, 1'b1);
        check("s_rearm_cs", s_checksum, 32'h0);
        check("s_rearm_ready", s_in_ready, 1'b1);

        repeat (2) @(negedge clock);
        check("pending_writes", q.size(), 0);
        check("s_pending_writes", sq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
